spi_ram: RTL and testbench
==========================

Name: spi_ram

Overview:
- Single-port synchronous byte RAM that consumes the 10-bit command words produced by the SPI slave (`rx_data`/`rx_valid`).
- Returns read data to the SPI slave over `tx_data`/`tx_valid`, which the slave shifts out on MISO.
- Holds separate write and read address pointers loaded by command words.
- Together with the SPI slave it forms the SPI-to-memory wrapper.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words.
- ADDR_SIZE, 8, pointer width; must satisfy 2**ADDR_SIZE >= MEM_DEPTH and ADDR_SIZE <= 8.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- din  input  10  command word from SPI slave rx_data; din[9:8] opcode, din[7:0] payload.
- rx_valid  input  1  din qualifier; high for one clk per received word.
- dout  output  8  read data to SPI slave tx_data.
- tx_valid  output  1  dout qualifier to SPI slave.

Behaviour:
- Reset (rst_n low at clk edge):
  - dout=8'h00, tx_valid=0, wr_addr=0, rd_addr=0.
  - Memory array contents are not cleared.
  - Reset overrides any rx_valid in the same cycle.
- Command decode applies only on a clk edge with rst_n=1 and rx_valid=1, by din[9:8]:
  - 2'b00 WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0]; tx_valid <= 0.
  - 2'b01 WR_DATA: mem[wr_addr] <= din[7:0]; tx_valid <= 0.
  - 2'b10 RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0]; tx_valid <= 0.
  - 2'b11 RD_DATA: dout <= mem[rd_addr]; tx_valid <= 1.
- rx_valid=0: pointers and memory hold; tx_valid <= 0; dout holds its last value.
- Latency and handshake:
  - RD_DATA accepted at edge N gives dout valid with tx_valid=1 after edge N, a one-cycle pulse.
  - Back-to-back RD_DATA words on consecutive cycles keep tx_valid high for each, with dout updating each cycle.
  - No backpressure: the SPI slave must capture dout while tx_valid=1.
- Payload bits above ADDR_SIZE-1 in address commands are ignored.
- Addresses >= MEM_DEPTH (when MEM_DEPTH < 2**ADDR_SIZE):
  - WR_DATA is dropped; the memory is unchanged.
  - RD_DATA returns 8'h00 with tx_valid=1.
- Read-after-write: WR_DATA at edge N followed by RD_DATA to the same address at edge N+1 or later returns the new byte. No same-cycle conflict is possible, since there is one command per cycle.
- Read of a never-written location returns the array content (X in simulation); benches must not check it.
- Internal decode is a 2-state registered tracker:
  - States: IDLE and RD_PEND.
  - RD_ADDR moves to RD_PEND.
  - RD_DATA moves to IDLE.
  - A second RD_ADDR in RD_PEND reloads rd_addr and stays in RD_PEND.
  - RD_DATA in IDLE is still honoured, reading the last rd_addr.
  - State is visible only to assertions; it is not an output.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined:
  - After each accepted WR_DATA, wr_addr <= wr_addr+1.
  - After each accepted RD_DATA, rd_addr <= rd_addr+1.
  - Increments wrap from MEM_DEPTH-1 to 0.
  - An address command in the same word always takes priority.
- Undefined: pointers change only on WR_ADDR/RD_ADDR and reset.

Test Plan:
- rst_n=0 for 2 clk with rx_valid=1, din=10'h3FF -> dout=00, tx_valid=0, no memory write.
- din=10'h025 (WR_ADDR 0x25), then 10'h1A5 (WR_DATA A5), then 10'h225 (RD_ADDR 0x25), then 10'h300 (RD_DATA) -> one cycle after the last word: dout=A5, tx_valid=1 for exactly 1 clk, dout still A5 afterwards.
- Write 0x11 to addr 0x00 and 0x22 to addr 0xFF; RD_ADDR 0xFF; RD_DATA; RD_ADDR 0x00; RD_DATA -> dout 22 then 11; tx_valid low between reads.
- rx_valid=0 with din=10'h1FF for 10 clk after writing 0x5A at addr 0x10 -> RD of 0x10 still returns 5A.
- Assert rst_n=0 for 1 clk mid-sequence after RD_ADDR 0x40 (addr 0x40 previously holds 0x77, addr 0x00 holds 0x33); release; issue RD_DATA -> returns 33 (rd_addr reset to 0), tx_valid=1.
- With SPI_RAM_AUTO_INC_EN: WR_ADDR 0xFE, WR_DATA 01, WR_DATA 02, WR_DATA 03; RD_ADDR 0xFE, 3× RD_DATA -> dout sequence 01, 02, 03 (third from wrapped addr 0x00).

Source files
------------

// File: rtl/spi_ram.sv
// spi_ram: single-port byte RAM driven by 10-bit SPI slave command words.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst_n     synchronous active-low reset (pointers, dout, tx_valid; not the array)
//   din       command word: din[9:8] opcode, din[7:0] payload
//   rx_valid  din qualifier, one clk per received word
//   dout      read data towards the SPI slave
//   tx_valid  one-cycle qualifier for dout per accepted RD_DATA
//
// Opcodes: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
//
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment wr_addr
// after each WR_DATA and rd_addr after each RD_DATA, wrapping at MEM_DEPTH-1.
module spi_ram #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid
);

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  // Read-side tracker: RD_PEND means an address was loaded and not yet read.
  typedef enum logic {
    IDLE    = 1'b0,
    RD_PEND = 1'b1
  } state_e;

  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;

  op_e                  op_c;
  logic                 mem_we_c;
  logic                 wr_in_range_c;
  logic                 rd_in_range_c;
  logic [DATA_W-1:0]    rd_byte_c;

`ifdef SPI_RAM_AUTO_INC_EN
  // Pointer increment that wraps at the last implemented word.
  function automatic logic [ADDR_SIZE-1:0] inc_wrap(input logic [ADDR_SIZE-1:0] a);
    if (32'(a) == MEM_DEPTH - 1) begin
      return '0;
    end
    return a + ADDR_SIZE'(1);
  endfunction
`endif

  // Opcode and address range qualification.
  always_comb begin
    op_c          = op_e'(din[9:8]);
    wr_in_range_c = (32'(wr_addr_q) < MEM_DEPTH);
    rd_in_range_c = (32'(rd_addr_q) < MEM_DEPTH);
    rd_byte_c     = rd_in_range_c ? mem[rd_addr_q] : '0;
  end

  // Command decode and next-state computation.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    mem_we_c   = 1'b0;

    if (rx_valid) begin
      unique case (op_c)
        OP_WR_ADDR: begin
          wr_addr_d = din[ADDR_SIZE-1:0];
        end
        OP_WR_DATA: begin
          // Out-of-range writes are silently dropped.
          mem_we_c = wr_in_range_c;
`ifdef SPI_RAM_AUTO_INC_EN
          wr_addr_d = inc_wrap(wr_addr_q);
`endif
        end
        OP_RD_ADDR: begin
          rd_addr_d = din[ADDR_SIZE-1:0];
          state_d   = RD_PEND;
        end
        OP_RD_DATA: begin
          // Honoured in IDLE too: reads the last loaded rd_addr.
          dout_d     = rd_byte_c;
          tx_valid_d = 1'b1;
          state_d    = IDLE;
`ifdef SPI_RAM_AUTO_INC_EN
          rd_addr_d  = inc_wrap(rd_addr_q);
`endif
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage array; not cleared by reset, and reset blocks writes.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) begin
      mem[wr_addr_q] <= din[DATA_W-1:0];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

  // A read response always returns the tracker to IDLE.
  a_tx_implies_idle: assert property (@(posedge clk) disable iff (!rst_n)
    tx_valid_q |-> (state_q == IDLE));

  // A freshly loaded read address leaves the tracker pending.
  a_rd_addr_pends: assert property (@(posedge clk) disable iff (!rst_n)
    (rx_valid && din[9:8] == 2'b10) |=> (state_q == RD_PEND));

endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: scoreboard bench for spi_ram. Expected read bytes are pushed
// when RD_DATA is driven and popped whenever the DUT raises tx_valid.
module tb_spi_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  int n_checks;
  int n_fail;

  logic [7:0] model   [256];
  bit         written [256];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic [7:0] exp_q [$];

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one word for one clk and update the reference model.
  task automatic send(input logic [9:0] w);
    din      = w;
    rx_valid = 1'b1;
    case (w[9:8])
      2'b00: m_wr = w[7:0];
      2'b01: begin
        model[m_wr]   = w[7:0];
        written[m_wr] = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
        m_wr = m_wr + 8'd1;
`endif
      end
      2'b10: m_rd = w[7:0];
      default: begin
        exp_q.push_back(model[m_rd]);
`ifdef SPI_RAM_AUTO_INC_EN
        m_rd = m_rd + 8'd1;
`endif
      end
    endcase
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    din      = 10'h000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with a live RD_DATA word on din; it must be ignored.
  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    din      = 10'h3FF;
    repeat (n) begin
      @(posedge clk);
      #1;
      check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
      check_eq("rst_dout", 32'(dout), 32'd0);
    end
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    din      = 10'h000;
    m_wr     = 8'h00;
    m_rd     = 8'h00;
  endtask

  task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
    send({2'b00, a});
    send({2'b01, d});
  endtask

  task automatic read_byte(input logic [7:0] a);
    send({2'b10, a});
    send({2'b11, 8'h00});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (tx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("tx_spurious", 32'(tx_valid), 32'd0);
      end else begin
        check_eq("rd_data", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = 10'h000;
    m_wr     = 8'h00;
    m_rd     = 8'h00;
    for (int i = 0; i < 256; i++) begin
      model[i]   = 8'h00;
      written[i] = 1'b0;
    end

    do_reset(2);
    idle(1);
    check_eq("post_rst_tx_valid", 32'(tx_valid), 32'd0);

    // Basic write then read with single-cycle tx_valid pulse.
    send(10'h025);
    send(10'h1A5);
    send(10'h225);
    send(10'h300);
    check_eq("pulse_hi", 32'(tx_valid), 32'd1);
    check_eq("pulse_dout", 32'(dout), 32'hA5);
    idle(1);
    check_eq("pulse_lo", 32'(tx_valid), 32'd0);
    check_eq("dout_hold", 32'(dout), 32'hA5);

    // Address extremes, tx_valid low between reads.
    write_byte(8'h00, 8'h11);
    write_byte(8'hFF, 8'h22);
    read_byte(8'hFF);
    send({2'b10, 8'h00});
    check_eq("gap_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("gap_dout", 32'(dout), 32'h22);
    send(10'h300);
    idle(1);

    // rx_valid low with garbage on din must change nothing.
    write_byte(8'h10, 8'h5A);
    din = 10'h1FF;
    repeat (10) begin
      @(posedge clk);
      #1;
      check_eq("novalid_tx", 32'(tx_valid), 32'd0);
    end
    din = 10'h000;
    read_byte(8'h10);
    idle(1);

    // Reset between RD_ADDR and RD_DATA clears rd_addr but not memory.
    write_byte(8'h00, 8'h33);
    write_byte(8'h40, 8'h77);
    send({2'b10, 8'h40});
    do_reset(1);
    send(10'h300);
    check_eq("mid_rst_tx", 32'(tx_valid), 32'd1);
    check_eq("mid_rst_dout", 32'(dout), 32'h33);
    idle(1);

    // Consecutive writes and back-to-back reads near the top of memory.
    send({2'b00, 8'hFE});
    send({2'b01, 8'h01});
    send({2'b01, 8'h02});
    send({2'b01, 8'h03});
    send({2'b10, 8'hFE});
    send(10'h300);
    send(10'h300);
    check_eq("b2b_tx", 32'(tx_valid), 32'd1);
    send(10'h300);
    idle(2);

    // Random traffic: reads only of locations already written.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 0) begin
        write_byte(a, 8'($urandom_range(0, 255)));
      end else if (written[a]) begin
        read_byte(a);
      end else begin
        idle(1);
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
